// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU behind a valid/ready handshake; MUL iterates one bit per cycle.
// Define SEQ_ALU_DIV_EN to add the iterative restoring divider for DIV (1100) / REM (1101).
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [3:0]       ALUCtrl_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b0110;
    localparam logic [3:0] OP_SRAI = 4'b0111;
    localparam logic [3:0] OP_LSW  = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1010;
    localparam logic [3:0] OP_NOP  = 4'b1011;
    localparam logic [3:0] OP_DIV  = 4'b1100;
    localparam logic [3:0] OP_REM  = 4'b1101;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] final_res;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, acc_nx;

    function automatic logic [WIDTH-1:0] single_result(input logic [3:0]       op,
                                                       input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] a_s;
        logic [SH_W-1:0]         sh;
        logic [WIDTH-1:0]        r;
        a_s = a;
        sh  = b[SH_W-1:0];
        r   = '0;
        case (op)
            OP_AND:                  r = a & b;
            OP_XOR:                  r = a ^ b;
            OP_SLL:                  r = a << sh;
            OP_ADD, OP_ADDI, OP_LSW: r = a + b;
            OP_SUB, OP_BEQ:          r = a - b;
            OP_SRAI:                 r = a_s >>> sh;
            OP_OR:                   r = a | b;
            OP_NOP, OP_DIV, OP_REM:  r = '0;
            default:                 r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_iter(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
`else
        return op == OP_MUL;
`endif
    endfunction

    assign single_res = single_result(ALUCtrl_i, data1_i, data2_i);
    assign accept     = valid_i & ready_o;
    assign acc_nx     = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SEQ_ALU_DIV_EN
    logic [3:0]       op_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, rem_nx, quo_nx;
    logic [WIDTH:0]   trial;
    logic             take;

    // Restoring step; a zero divisor always "fits", giving all-ones quotient and remainder = dividend.
    always_comb begin
        trial  = {rem_q, quo_q[WIDTH-1]};
        take   = trial >= {1'b0, dvsr_q};
        rem_nx = take ? WIDTH'(trial - {1'b0, dvsr_q}) : trial[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], take};
    end

    always_comb begin
        final_res = acc_nx;
        case (op_q)
            OP_DIV:  final_res = quo_nx;
            OP_REM:  final_res = rem_nx;
            default: final_res = acc_nx;
        endcase
    end
`else
    assign final_res = acc_nx;
`endif

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) state_d = is_iter(ALUCtrl_i) ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                if (cnt_q == CNT_ONE) state_d = S_DONE;
            end
            S_DONE: begin
                valid_o = 1'b1;
                if (ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_o  <= '0;
            Zero_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (is_iter(ALUCtrl_i)) begin
                    cnt_q <= CNT_LOAD;
                end else begin
                    data_o <= single_res;
                    Zero_o <= (single_res == '0);
                end
            end else if (state_q == S_BUSY) begin
                cnt_q <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    data_o <= final_res;
                    Zero_o <= (final_res == '0);
                end
            end
        end
    end

    // Operand/iteration registers carry no control meaning and need no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            acc_q    <= '0;
            mcand_q  <= data1_i;
            mplier_q <= data2_i;
`ifdef SEQ_ALU_DIV_EN
            op_q     <= ALUCtrl_i;
            rem_q    <= '0;
            quo_q    <= data1_i;
            dvsr_q   <= data2_i;
`endif
        end else if (state_q == S_BUSY) begin
            acc_q    <= acc_nx;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
`ifdef SEQ_ALU_DIV_EN
            rem_q    <= rem_nx;
            quo_q    <= quo_nx;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] data1_i = '0;
    logic [W-1:0] data2_i = '0;
    logic [3:0]   ALUCtrl_i = '0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [W-1:0] data_o;
    logic         Zero_o;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .data1_i(data1_i), .data2_i(data2_i), .ALUCtrl_i(ALUCtrl_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .Zero_o(Zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        int unsigned      sh;
        logic signed [W-1:0] s;
        logic [2*W-1:0]   prod;
        sh   = b % W;
        s    = a;
        prod = a * b;
        case (op)
            4'd0:             return a & b;
            4'd1:             return a ^ b;
            4'd2:             return a << sh;
            4'd3, 4'd6, 4'd8: return a + b;
            4'd4, 4'd9:       return a - b;
            4'd5:             return prod[W-1:0];
            4'd7:             return s >>> sh;
            4'd10:            return a | b;
`ifdef SEQ_ALU_DIV_EN
            4'd12:            return (b == 0) ? '1 : a / b;
            4'd13:            return (b == 0) ? a : a % b;
`endif
            default:          return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
        if (op == 4'd12 || op == 4'd13) return W + 1;
`endif
        return (op == 4'd5) ? W + 1 : 1;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        logic [W-1:0] exp;
        int           lat, exp_lat, n;
        bit           rdy_seen;
        exp     = ref_result(op, a, b);
        exp_lat = ref_latency(op);
        n = 0;
        while (!ready_o && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_op", ready_o, 1);
        valid_i = 1'b1; ALUCtrl_i = op; data1_i = a; data2_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0; data1_i = $urandom; data2_i = $urandom; ALUCtrl_i = 4'($urandom);
        lat = 1; rdy_seen = 0;
        while (!valid_o && lat < 100) begin
            if (ready_o) rdy_seen = 1;
            valid_i = 1'b1;
            @(posedge clk); #1; lat++;
        end
        valid_i = 1'b0;
        check($sformatf("latency op%0d", op), lat, exp_lat);
        if (exp_lat > 1) check("ready_in_busy", rdy_seen, 0);
        check($sformatf("data op%0d %0h,%0h", op, a, b), data_o, exp);
        check($sformatf("zero op%0d", op), Zero_o, exp == '0);
        check("ready_in_done", ready_o, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("held_valid", valid_o, 1);
            check("held_data", data_o, exp);
            check("held_ready", ready_o, 0);
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        check("valid_after_take", valid_o, 0);
        check("ready_after_take", ready_o, 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit           seen;
        logic [W-1:0] b;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b1;
        #1;
        check("reset_valid", valid_o, 0);
        check("reset_data", data_o, 0);
        check("reset_zero", Zero_o, 0);
        check("reset_ready", ready_o, 1);

        run_op(4'd3, 32'h7FFF_FFFF, 32'h1, 0);
        run_op(4'd9, 32'd5, 32'd5, 0);
        run_op(4'd7, 32'h8000_0000, 32'h24, 0);
        run_op(4'd5, 32'h0000_FFFF, 32'h0001_0001, 0);
        run_op(4'd12, 32'd100, 32'd7, 0);
        run_op(4'd13, 32'd100, 32'd7, 0);
        run_op(4'd12, 32'h1234_5678, 32'd0, 0);
        run_op(4'd13, 32'd9, 32'd0, 0);
        run_op(4'd11, 32'hFFFF_FFFF, 32'h1, 0);
        run_op(4'd14, 32'h55, 32'h1, 0);
        run_op(4'd3, 32'd3, 32'd4, 10);

        // Reset in the middle of a MUL: previous result (7) must vanish immediately.
        valid_i = 1'b1; ALUCtrl_i = 4'd5; data1_i = 32'h1234; data2_i = 32'h5678;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_i = 1'b0;
        #1;
        check("midrst_valid", valid_o, 0);
        check("midrst_data", data_o, 0);
        check("midrst_zero", Zero_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_o) seen = 1;
        end
        check("midrst_no_result", seen, 0);
        check("midrst_ready", ready_o, 1);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = $urandom_range(0, 40);
                default: b = $urandom;
            endcase
            run_op(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0) ? b : $urandom, b,
                   $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the single-cycle datapath ALU. Single-cycle operations complete one cycle after acceptance; MUL (and optionally DIV/REM) run iteratively over WIDTH cycles, so the unit sits behind a valid/ready handshake between the ID/EX pipeline register and the EX/MEM stage. The existing 4-bit ALU control encoding is retained, so the ALU control unit drives it unchanged.

## Interface
- WIDTH, 32, datapath width in bits (≥ 4, power of two)
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  operand/opcode bundle present
- ready_o  out  1  unit can accept a bundle this cycle
- data1_i  in  WIDTH  operand A
- data2_i  in  WIDTH  operand B / shift amount
- ALUCtrl_i  in  4  operation code
- valid_o  out  1  result present on data_o/Zero_o
- ready_i  in  1  consumer takes result this cycle
- data_o  out  WIDTH  registered result
- Zero_o  out  1  registered, 1 iff data_o == 0

## Operation
- Opcodes: 0000 AND, 0001 XOR, 0010 SLL, 0011 ADD, 0100 SUB, 0101 MUL, 0110 ADDI (=ADD), 0111 SRAI (signed arithmetic right shift), 1000 LSW (=ADD, address), 1001 BEQ (=SUB, consumer uses Zero_o), 1010 OR, 1011 NoOp (result 0), 1100 DIV, 1101 REM; 1110/1111 and disabled DIV/REM produce result 0.
- Arithmetic modulo 2^WIDTH; no overflow flag. Shift amount = data2_i[log2(WIDTH)-1:0], upper bits ignored.
- MUL: low WIDTH bits of unsigned product, shift-add one bit per cycle.
- DIV/REM: unsigned restoring division, one quotient bit per cycle. Divide by zero: DIV → all ones, REM → data1_i.
- Operands and opcode captured into internal registers on acceptance; inputs may change afterwards.
- FSM: IDLE (ready_o=1) –accept (valid_i & ready_o)→ single-cycle op: DONE; iterative op: BUSY with counter = WIDTH. BUSY decrements counter each cycle; at counter reaching 1 the final result is written and → DONE. DONE (valid_o=1, outputs held stable) –ready_i→ IDLE.
- ready_o is 0 in BUSY and DONE; no new bundle is accepted while a result is unconsumed.
- Zero_o is computed from the final result and registered together with data_o.

## Timing
- Reset values: data_o 0, Zero_o 0, valid_o 0, FSM IDLE (ready_o 1 once rst_i deasserted), counter 0.
- Latency acceptance edge → valid_o: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/DIV/REM.
- Throughput: one op per 2 cycles (single-cycle ops, ready_i held 1); WIDTH+2 cycles for iterative ops.
- data_o/Zero_o change only on the edge entering DONE; stable while valid_o=1 and ready_i=0 (back-pressure unlimited).
- valid_i while ready_o=0 is ignored; upstream must hold the bundle.
- Reset mid-BUSY or mid-DONE: operation discarded, all outputs return to reset values immediately (asynchronous), no result emitted after release.
- Counter never wraps: it is loaded only in IDLE and only decremented in BUSY.

## Configuration
- SEQ_ALU_DIV_EN defined: DIV (1100) and REM (1101) implemented as above, sharing the iterative counter/FSM with MUL.
- Not defined: divider datapath absent; 1100/1101 treated as single-cycle ops with result 0 and Zero_o 1.

## Test plan
- Reset: hold rst_i=0 3 cycles, release → valid_o=0, data_o=0, Zero_o=0, ready_o=1.
- WIDTH=32, ADD 0x7FFFFFFF+1 → valid_o after 1 cycle, data_o=0x80000000, Zero_o=0; BEQ 5,5 → data_o=0, Zero_o=1; SRAI 0x80000000 by 4 (data2_i=0x24, upper bits ignored) → 0xF8000000.
- MUL 0xFFFF×0x10001 → valid_o exactly 33 cycles after acceptance, data_o=0xFFFFFFFF; ready_o=0 throughout; new valid_i during BUSY ignored.
- Back-pressure: ADD 3+4 with ready_i=0 for 10 cycles → data_o=7 held, valid_o=1, ready_o=0; ready_i=1 → IDLE next cycle.
- With SEQ_ALU_DIV_EN: DIV 100/7 → 14, REM 100/7 → 2, DIV x/0 → 0xFFFFFFFF, REM 9/0 → 9; without macro DIV 100/7 → 0, Zero_o=1, latency 1.
- Reset asserted at cycle 10 of a MUL → outputs to reset values immediately; after release no valid_o until a new op is accepted.
